rx_block_sync: RTL

//  Receive-side 64b/66b block-lock FSM, per lane. It is the checker for the sync headers the TX path generates.

---
 rtl/rx_block_sync.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rx_block_sync.sv
// Per-lane 64b/66b block-lock FSM: walks gearbox alignment with slip pulses until 64 clean sync headers.
// Latency: every response (slip_o, block_lock_o, err_cnt_o) is registered, visible 1 clk after the header.
// Backpressure: none; head_valid_i is simply ignored while the gearbox settles after a slip.
module rx_block_sync #(
   parameter int P_SH_CNT_MAX = 64,
   parameter int P_INVLD_MAX  = 16,
   parameter int P_SLIP_WAIT  = 32,
   parameter int P_ERR_CNT_W  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [1:0]             head_i,
   input  logic                   head_valid_i,
   output logic                   slip_o,
   output logic                   block_lock_o,
   input  logic                   err_clr_i,
   output logic [P_ERR_CNT_W-1:0] err_cnt_o
);

   localparam int SH_W   = $clog2(P_SH_CNT_MAX + 1);
   localparam int INV_W  = $clog2(P_INVLD_MAX + 1);
   localparam int WAIT_W = $clog2(P_SLIP_WAIT + 1);

   typedef enum logic [1:0] {
      RESET_CNT = 2'd0,
      TEST      = 2'd1,
      SLIP_WAIT = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [SH_W-1:0]   sh_cnt, sh_cnt_nxt;
   logic [INV_W-1:0]  invld_cnt, invld_cnt_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic              slip_nxt;
   logic              lock_nxt;
   logic              head_ok;
   logic              head_take;

   // 01 and 10 are the only legal sync headers; headers only count while testing
   assign head_ok   = head_i[1] ^ head_i[0];
   assign head_take = (state == TEST) && head_valid_i;

   // State, window counters and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= RESET_CNT;
         sh_cnt       <= '0;
         invld_cnt    <= '0;
         wait_cnt     <= '0;
         slip_o       <= 1'b0;
         block_lock_o <= 1'b0;
      end else begin
         state        <= state_nxt;
         sh_cnt       <= sh_cnt_nxt;
         invld_cnt    <= invld_cnt_nxt;
         wait_cnt     <= wait_cnt_nxt;
         slip_o       <= slip_nxt;
         block_lock_o <= lock_nxt;
      end
   end

   // Next-state: header window evaluation, loss-of-lock has priority over window end
   always_comb begin
      state_nxt     = state;
      sh_cnt_nxt    = sh_cnt;
      invld_cnt_nxt = invld_cnt;
      wait_cnt_nxt  = wait_cnt;
      slip_nxt      = 1'b0;
      lock_nxt      = block_lock_o;
      case (state)
         RESET_CNT: begin
            // Any header arriving here is dropped; the new window starts clean
            sh_cnt_nxt    = '0;
            invld_cnt_nxt = '0;
            state_nxt     = TEST;
         end
         TEST: begin
            if (head_valid_i) begin
               sh_cnt_nxt = sh_cnt + SH_W'(1);
               if (!head_ok) begin
                  invld_cnt_nxt = invld_cnt + INV_W'(1);
               end
               if (!block_lock_o) begin
                  // Hunting: a single bad header means wrong alignment, slip immediately
                  if (!head_ok) begin
                     slip_nxt     = 1'b1;
                     wait_cnt_nxt = '0;
                     state_nxt    = SLIP_WAIT;
                  end else if (sh_cnt_nxt == SH_W'(P_SH_CNT_MAX)) begin
                     lock_nxt  = 1'b1;
                     state_nxt = RESET_CNT;
                  end
               end else begin
                  // Locked: tolerate errors until too many land in one window
                  if (invld_cnt_nxt == INV_W'(P_INVLD_MAX)) begin
                     lock_nxt     = 1'b0;
                     slip_nxt     = 1'b1;
                     wait_cnt_nxt = '0;
                     state_nxt    = SLIP_WAIT;
                  end else if (sh_cnt_nxt == SH_W'(P_SH_CNT_MAX)) begin
                     state_nxt = RESET_CNT;
                  end
               end
            end
         end
         SLIP_WAIT: begin
            // The slip-pulse cycle is wait_cnt==0, so the wait spans P_SLIP_WAIT cycles in total
            if (wait_cnt == WAIT_W'(P_SLIP_WAIT - 1)) begin
               state_nxt = RESET_CNT;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            state_nxt = RESET_CNT;
         end
      endcase
   end

   // Saturating count of bad headers seen while locked; clear wins, loss of lock keeps the count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_cnt_o <= '0;
      end else if (err_clr_i) begin
         err_cnt_o <= '0;
      end else if (head_take && !head_ok && block_lock_o && (err_cnt_o != '1)) begin
         err_cnt_o <= err_cnt_o + P_ERR_CNT_W'(1);
      end
   end

endmodule
